// File: rtl/main_fsm_control.sv
// Multicycle main control FSM for the 64-bit RISC-V datapath.
// Sequences fetch/decode/execute/memory/writeback for add, sub, addi, ld, sd, beq.
//
// state      | meaning
// RESET (0)  | post-reset idle cycle, all controls low
// FETCH (1)  | PC+4 on the ALU, wait MEM_LAT for instruction, then load IR and PC
// DECODE(2)  | latch register-file outputs A/B, dispatch on opcode/funct
// R_ADD (3)  | ALUOut <= A + B
// R_SUB (4)  | ALUOut <= A - B
// ADDI  (5)  | ALUOut <= A + imm
// MEM_ADDR(6)| ALUOut <= A + imm (effective address for ld/sd)
// LD_WAIT(7) | wait MEM_LAT for load data, then latch MDR
// SD_WR (8)  | one-cycle store strobe, then wait MEM_LAT for the write to finish
// BRANCH(9)  | compare A - B, PC <= branch target when zero
// WB_ALU(10) | register file <= ALUOut
// WB_LD (11) | register file <= MDR
// ILLEGAL(15)| unsupported instruction, parked until reset
//
// MEM_LAT must lie in 1..7 (3-bit wait counter).
module main_fsm_control #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       pcSrc,
  output logic       load_ir,
  output logic       loadA,
  output logic       loadB,
  output logic       loadAluOut,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       dmemWr,
  output logic       memToReg,
  output logic       regWrite,
  output logic       loadMDR,
  output logic       illegal,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_R_ADD    = 4'd3,
    S_R_SUB    = 4'd4,
    S_ADDI     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_LD_WAIT  = 4'd7,
    S_SD_WR    = 4'd8,
    S_BRANCH   = 4'd9,
    S_WB_ALU   = 4'd10,
    S_WB_LD    = 4'd11,
    S_ILLEGAL  = 4'd15
  } state_t;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       pcsrc;
    logic       ir;
    logic       la;
    logic       lb;
    logic       lalu;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic       dw;
    logic       m2r;
    logic       rw;
    logic       lmdr;
    logic       ill;
  } ctl_t;

  localparam logic [2:0] LAT    = 3'(MEM_LAT);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  ctl_t       ctl_q;

  // Moore control word for a given state and wait-counter value
  function automatic ctl_t ctl_of(state_t s, logic [2:0] c);
    ctl_t k;
    k = '0;
    case (s)
      S_FETCH: begin
        k.asb = 2'b01;
        k.aop = 3'b001;
        k.ir  = (c == LAT);
        k.pcw = (c == LAT);
      end
      S_DECODE: begin
        k.la = 1'b1;
        k.lb = 1'b1;
      end
      S_R_ADD, S_R_SUB: begin
        k.asa  = 1'b1;
        k.aop  = (s == S_R_SUB) ? 3'b010 : 3'b001;
        k.lalu = 1'b1;
      end
      S_ADDI, S_MEM_ADDR: begin
        k.asa  = 1'b1;
        k.asb  = 2'b10;
        k.aop  = 3'b001;
        k.lalu = 1'b1;
      end
      S_LD_WAIT: k.lmdr = (c == LAT);
      S_SD_WR:   k.dw   = (c == 3'd0);
      S_BRANCH: begin
        k.asa   = 1'b1;
        k.aop   = 3'b010;
        k.pcwc  = 1'b1;
        k.pcsrc = 1'b1;
      end
      S_WB_ALU: k.rw = 1'b1;
      S_WB_LD: begin
        k.rw  = 1'b1;
        k.m2r = 1'b1;
      end
      S_ILLEGAL: k.ill = 1'b1;
      default: ;
    endcase
    return k;
  endfunction

  // next-state and wait-counter logic; the counter rests at 0 outside the wait states
  always_comb begin
    state_nxt = state;
    cnt_nxt   = 3'd0;
    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        if (cnt == LAT) state_nxt = S_DECODE;
        else            cnt_nxt   = cnt + 3'd1;
      end
      S_DECODE: begin
        // sd is accepted with funct3 011 (RV64 encoding) as well as 111
        if (opcode == OP_R && funct3 == 3'b000 && funct7 == 7'b0000000)      state_nxt = S_R_ADD;
        else if (opcode == OP_R && funct3 == 3'b000 && funct7 == 7'b0100000) state_nxt = S_R_SUB;
        else if (opcode == OP_I && funct3 == 3'b000)                         state_nxt = S_ADDI;
        else if (opcode == OP_LD && funct3 == 3'b011)                        state_nxt = S_MEM_ADDR;
        else if (opcode == OP_SD && (funct3 == 3'b111 || funct3 == 3'b011))  state_nxt = S_MEM_ADDR;
        else if (opcode == OP_BR && funct3 == 3'b000)                        state_nxt = S_BRANCH;
        else                                                                 state_nxt = S_ILLEGAL;
      end
      S_R_ADD, S_R_SUB, S_ADDI: state_nxt = S_WB_ALU;
      S_MEM_ADDR: state_nxt = (opcode == OP_LD) ? S_LD_WAIT : S_SD_WR;
      S_LD_WAIT: begin
        if (cnt == LAT) state_nxt = S_WB_LD;
        else            cnt_nxt   = cnt + 3'd1;
      end
      S_SD_WR: begin
        if (cnt == LAT) state_nxt = S_FETCH;
        else            cnt_nxt   = cnt + 3'd1;
      end
      S_BRANCH, S_WB_ALU, S_WB_LD: state_nxt = S_FETCH;
      S_ILLEGAL: state_nxt = S_ILLEGAL;
      default:   state_nxt = S_RESET;
    endcase
  end

  // state, counter and the registered control word (precomputed from the next state)
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RESET;
      cnt   <= 3'd0;
      ctl_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ctl_q <= ctl_of(state_nxt, cnt_nxt);
    end
  end

  // write enables are masked while reset is high so an interrupted instruction commits nothing
  assign pcWrite     = (ctl_q.pcw | (ctl_q.pcwc & zero)) & ~reset;
  assign pcWriteCond = ctl_q.pcwc & ~reset;
  assign load_ir     = ctl_q.ir   & ~reset;
  assign loadA       = ctl_q.la   & ~reset;
  assign loadB       = ctl_q.lb   & ~reset;
  assign loadAluOut  = ctl_q.lalu & ~reset;
  assign dmemWr      = ctl_q.dw   & ~reset;
  assign regWrite    = ctl_q.rw   & ~reset;
  assign loadMDR     = ctl_q.lmdr & ~reset;
  assign pcSrc       = ctl_q.pcsrc;
  assign ALUSrcA     = ctl_q.asa;
  assign ALUSrcB     = ctl_q.asb;
  assign ALUOp       = ctl_q.aop;
  assign memToReg    = ctl_q.m2r;
  assign illegal     = ctl_q.ill;
  assign state_out   = state;

endmodule
